// File: rtl/qam_mapper.sv
// qam_mapper
//   Collects a serial bit stream into BPSK / QPSK / 16-QAM symbols and emits
//   Gray-mapped signed I/Q samples with per-frame start/end markers.
//   The modulation is latched at the first bit of each frame.
//
// Ports
//   map_clk    : clock, rising edge
//   map_rst    : synchronous reset, active high
//   din        : serial data bit (first bit of a symbol is b0 / MSB)
//   din_valid  : din accepted on every cycle this is high
//   mod_sel    : 0=BPSK 1=QPSK 2=16-QAM 3=BPSK, sampled at frame start
//   sym_i/q    : signed I/Q sample, held while sym_valid is low
//   sym_valid  : one-cycle pulse per symbol
//   sym_sof    : with sym_valid on symbol 0 of a frame
//   sym_eof    : with sym_valid on symbol FRAME_SYM-1
//   sym_idx    : symbol index within the frame
module qam_mapper #(
  parameter int WIDTH     = 16,
  parameter int FRAME_SYM = 48,
  parameter int LVL_BPSK  = 16384,
  parameter int LVL_QPSK  = 11585,
  parameter int LVL_16QAM = 5181
) (
  input  logic                         map_clk,
  input  logic                         map_rst,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic [1:0]                   mod_sel,
  output logic signed [WIDTH-1:0]      sym_i,
  output logic signed [WIDTH-1:0]      sym_q,
  output logic                         sym_valid,
  output logic                         sym_sof,
  output logic                         sym_eof,
  output logic [$clog2(FRAME_SYM)-1:0] sym_idx
);

  localparam int IDX_W = $clog2(FRAME_SYM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SYM - 1);

  localparam logic signed [WIDTH-1:0] POS_B  = WIDTH'(LVL_BPSK);
  localparam logic signed [WIDTH-1:0] NEG_B  = WIDTH'(-LVL_BPSK);
  localparam logic signed [WIDTH-1:0] POS_Q  = WIDTH'(LVL_QPSK);
  localparam logic signed [WIDTH-1:0] NEG_Q  = WIDTH'(-LVL_QPSK);
  localparam logic signed [WIDTH-1:0] POS_1L = WIDTH'(LVL_16QAM);
  localparam logic signed [WIDTH-1:0] NEG_1L = WIDTH'(-LVL_16QAM);
  localparam logic signed [WIDTH-1:0] POS_3L = WIDTH'(3 * LVL_16QAM);
  localparam logic signed [WIDTH-1:0] NEG_3L = WIDTH'(-3 * LVL_16QAM);

  typedef enum logic {IDLE, COLLECT} state_t;
  typedef enum logic [1:0] {MOD_BPSK = 2'd0, MOD_QPSK = 2'd1, MOD_QAM16 = 2'd2} mode_t;

  state_t           state;
  mode_t            mode_q;
  mode_t            mode_eff;
  logic [1:0]       bit_cnt;
  logic [1:0]       last_cnt;
  logic [3:0]       shreg;
  logic [3:0]       bits;
  logic [IDX_W-1:0] sym_cnt;
  logic             sym_done;
  logic signed [WIDTH-1:0] map_i;
  logic signed [WIDTH-1:0] map_q;

  // 16-QAM axis: first bit is the sign, second selects inner (1) / outer (0).
  function automatic logic signed [WIDTH-1:0] qam_axis(input logic b_hi, input logic b_lo);
    if (b_hi) return b_lo ? POS_1L : POS_3L;
    else      return b_lo ? NEG_1L : NEG_3L;
  endfunction

  always_comb begin
    // The first bit of a frame must be mapped with the incoming mod_sel,
    // since the latched mode only updates on that same edge.
    mode_eff = mode_q;
    if (state == IDLE) begin
      case (mod_sel)
        2'd1:    mode_eff = MOD_QPSK;
        2'd2:    mode_eff = MOD_QAM16;
        default: mode_eff = MOD_BPSK;
      endcase
    end

    case (mode_eff)
      MOD_QPSK:  last_cnt = 2'd1;
      MOD_QAM16: last_cnt = 2'd3;
      default:   last_cnt = 2'd0;
    endcase

    // Earlier bits sit in shreg with b0 highest; the current bit goes last.
    bits     = {shreg[2:0], din};
    sym_done = din_valid && (bit_cnt == last_cnt);

    map_i = '0;
    map_q = '0;
    case (mode_eff)
      MOD_QPSK: begin
        map_i = bits[1] ? POS_Q : NEG_Q;
        map_q = bits[0] ? POS_Q : NEG_Q;
      end
      MOD_QAM16: begin
        map_i = qam_axis(bits[3], bits[2]);
        map_q = qam_axis(bits[1], bits[0]);
      end
      default: begin
        map_i = bits[0] ? POS_B : NEG_B;
        map_q = '0;
      end
    endcase
  end

  always_ff @(posedge map_clk) begin
    if (map_rst) begin
      state     <= IDLE;
      mode_q    <= MOD_BPSK;
      bit_cnt   <= '0;
      shreg     <= '0;
      sym_cnt   <= '0;
      sym_i     <= '0;
      sym_q     <= '0;
      sym_valid <= 1'b0;
      sym_sof   <= 1'b0;
      sym_eof   <= 1'b0;
      sym_idx   <= '0;
    end else begin
      sym_valid <= 1'b0;
      sym_sof   <= 1'b0;
      sym_eof   <= 1'b0;
      if (din_valid) begin
        shreg <= bits;
        if (state == IDLE) begin
          mode_q <= mode_eff;
          state  <= COLLECT;
        end
        if (sym_done) begin
          sym_i     <= map_i;
          sym_q     <= map_q;
          sym_valid <= 1'b1;
          sym_sof   <= (sym_cnt == '0);
          sym_eof   <= (sym_cnt == LAST_IDX);
          sym_idx   <= sym_cnt;
          bit_cnt   <= '0;
          if (sym_cnt == LAST_IDX) begin
            sym_cnt <= '0;
            state   <= IDLE;
          end else begin
            sym_cnt <= sym_cnt + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper.sv
module tb_qam_mapper;

  localparam int WIDTH     = 16;
  localparam int FRAME_SYM = 48;
  localparam int LB = 16384;
  localparam int LQ = 11585;
  localparam int L1 = 5181;

  logic map_clk = 1'b0;
  logic map_rst, din, din_valid;
  logic [1:0] mod_sel;
  logic signed [WIDTH-1:0] sym_i, sym_q;
  logic sym_valid, sym_sof, sym_eof;
  logic [$clog2(FRAME_SYM)-1:0] sym_idx;

  qam_mapper #(
    .WIDTH(WIDTH), .FRAME_SYM(FRAME_SYM),
    .LVL_BPSK(LB), .LVL_QPSK(LQ), .LVL_16QAM(L1)
  ) dut (
    .map_clk(map_clk), .map_rst(map_rst), .din(din), .din_valid(din_valid),
    .mod_sel(mod_sel), .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid),
    .sym_sof(sym_sof), .sym_eof(sym_eof), .sym_idx(sym_idx)
  );

  always #5 map_clk = ~map_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of symbols, a symbol is a queue of bits.
  bit m_in_frame;
  int m_mode, m_k;
  bit m_bits[$];
  int e_i, e_q, e_idx;
  bit e_v, e_sof, e_eof;

  function automatic int lvl_of(input int mode);
    return (mode == 0) ? LB : (mode == 1) ? LQ : L1;
  endfunction

  function automatic int sgn(input bit b);
    return b ? 1 : -1;
  endfunction

  task automatic model_step(input bit rst, input bit v, input bit d, input int ms);
    int need, L;
    e_v = 0; e_sof = 0; e_eof = 0;
    if (rst) begin
      m_in_frame = 0; m_mode = 0; m_k = 0; m_bits.delete();
      e_i = 0; e_q = 0; e_idx = 0;
      return;
    end
    if (!v) return;
    if (!m_in_frame) begin
      m_mode = (ms == 3) ? 0 : ms;
      m_in_frame = 1;
    end
    m_bits.push_back(d);
    need = (m_mode == 0) ? 1 : (m_mode == 1) ? 2 : 4;
    if (m_bits.size() == need) begin
      L = lvl_of(m_mode);
      case (m_mode)
        0: begin e_i = sgn(m_bits[0]) * L; e_q = 0; end
        1: begin e_i = sgn(m_bits[0]) * L; e_q = sgn(m_bits[1]) * L; end
        default: begin
          e_i = sgn(m_bits[0]) * (m_bits[1] ? 1 : 3) * L;
          e_q = sgn(m_bits[2]) * (m_bits[3] ? 1 : 3) * L;
        end
      endcase
      e_v = 1;
      e_sof = (m_k == 0);
      e_eof = (m_k == FRAME_SYM - 1);
      e_idx = m_k;
      m_k++;
      if (m_k == FRAME_SYM) begin
        m_k = 0;
        m_in_frame = 0;
      end
      m_bits.delete();
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare every output.
  task automatic cyc(input bit rst, input bit v, input bit d, input int ms);
    map_rst = rst; din_valid = v; din = d; mod_sel = 2'(ms);
    @(posedge map_clk);
    model_step(rst, v, d, ms);
    #1;
    chk("sym_valid", int'(sym_valid), int'(e_v));
    chk("sym_sof",   int'(sym_sof),   int'(e_sof));
    chk("sym_eof",   int'(sym_eof),   int'(e_eof));
    chk("sym_i",     int'(sym_i),     e_i);
    chk("sym_q",     int'(sym_q),     e_q);
    chk("sym_idx",   int'(sym_idx),   e_idx);
  endtask

  typedef struct {
    int       ms;
    int       nb;
    bit [3:0] b;      // b[3] is the first bit sent
    int       exp_i;
    int       exp_q;
  } vec_t;

  vec_t vt[$];
  int nvalid, neof, eof_idx;
  bit [3:0] pat;

  initial begin
    map_rst = 1; din_valid = 0; din = 0; mod_sel = 0;
    model_step(1, 0, 0, 0);

    // Reset held with din_valid high: nothing may come out.
    for (int c = 0; c < 3; c++) cyc(1, 1, 1, 0);
    chk("rst_valid", int'(sym_valid), 0);
    chk("rst_i", int'(sym_i), 0);
    chk("rst_idx", int'(sym_idx), 0);
    cyc(0, 1, 1, 0);
    chk("first_sof", int'(sym_sof), 1);

    // Single-symbol vectors, each from a fresh reset.
    vt.push_back('{0, 1, 4'b1000,  16384,      0});
    vt.push_back('{0, 1, 4'b0000, -16384,      0});
    vt.push_back('{3, 1, 4'b1000,  16384,      0});
    vt.push_back('{1, 2, 4'b1000,  11585, -11585});
    vt.push_back('{1, 2, 4'b0100, -11585,  11585});
    vt.push_back('{2, 4, 4'b1001,  15543,  -5181});
    vt.push_back('{2, 4, 4'b1100,   5181, -15543});
    vt.push_back('{2, 4, 4'b0000, -15543, -15543});
    vt.push_back('{2, 4, 4'b0111,  -5181,   5181});
    vt.push_back('{2, 4, 4'b1011,  15543,   5181});
    foreach (vt[n]) begin
      cyc(1, 0, 0, 0);
      pat = vt[n].b;
      for (int j = 0; j < vt[n].nb; j++) cyc(0, 1, pat[3 - j], vt[n].ms);
      chk("vec_valid", int'(sym_valid), 1);
      chk("vec_i", int'(sym_i), vt[n].exp_i);
      chk("vec_q", int'(sym_q), vt[n].exp_q);
      chk("vec_sof", int'(sym_sof), 1);
    end

    // BPSK continuous 1,0,1 then hold.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0); chk("bpsk0", int'(sym_i), 16384);
    cyc(0, 1, 0, 0); chk("bpsk1", int'(sym_i), -16384); chk("bpsk1_v", int'(sym_valid), 1);
    cyc(0, 1, 1, 0); chk("bpsk2", int'(sym_i), 16384);  chk("bpsk2_idx", int'(sym_idx), 2);
    cyc(0, 0, 0, 0); chk("bpsk_hold", int'(sym_i), 16384);

    // QPSK with a 2-cycle gap between the bits.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 1); chk("qgap_v0", int'(sym_valid), 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1); chk("qgap_v1", int'(sym_valid), 0);
    cyc(0, 1, 0, 1);
    chk("qgap_i", int'(sym_i), 11585); chk("qgap_q", int'(sym_q), -11585);

    // Full QPSK frame with mod_sel switched mid-frame, then a 16-QAM frame.
    cyc(1, 0, 0, 0);
    nvalid = 0; neof = 0; eof_idx = -1;
    for (int n = 0; n < 2 * FRAME_SYM; n++) begin
      cyc(0, 1, 1'($urandom), (n >= 10) ? 2 : 1);
      if (sym_valid) nvalid++;
      if (sym_eof) begin neof++; eof_idx = int'(sym_idx); end
    end
    chk("frame_syms", nvalid, FRAME_SYM);
    chk("frame_eofs", neof, 1);
    chk("frame_eof_idx", eof_idx, FRAME_SYM - 1);
    cyc(0, 1, 1, 2); cyc(0, 1, 0, 2); cyc(0, 1, 0, 2);
    chk("qam_frame_wait", int'(sym_valid), 0);
    cyc(0, 1, 1, 2);
    chk("qam_frame_sof", int'(sym_sof), 1);
    chk("qam_frame_i", int'(sym_i), 15543);
    chk("qam_frame_q", int'(sym_q), -5181);

    // Reset in the middle of a 16-QAM symbol discards the partial bits.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 2); cyc(0, 1, 1, 2); cyc(0, 1, 1, 2);
    cyc(1, 0, 0, 2);
    for (int j = 0; j < 4; j++) cyc(0, 1, 0, 2);
    chk("mrst_i", int'(sym_i), -15543);
    chk("mrst_q", int'(sym_q), -15543);
    chk("mrst_sof", int'(sym_sof), 1);
    chk("mrst_idx", int'(sym_idx), 0);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 4000; c++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7,
          1'($urandom), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
